myproject_mac_seq: RTL and testbench
====================================

MYPROJECT_MAC_SEQ -- requirements
Module: myproject_mac_seq

Interface
REQ-001 The block SHALL have parameter N_IN, default 16, giving products per run (N_IN >= 2).
REQ-002 The block SHALL have parameter ACC_W, default 24, giving signed accumulator/result width (ACC_W >= 19).
REQ-003 The block SHALL have port ap_clk, input, 1 bit: the single clock, rising edge.
REQ-004 The block SHALL have port ap_rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-005 The block SHALL have port ap_start, input, 1 bit: run request, sampled only in IDLE.
REQ-006 The block SHALL have ports ap_done, ap_idle and ap_ready, each output, 1 bit: HLS-style block status.
REQ-007 The block SHALL have port bias, input, ACC_W bits: signed accumulator seed, sampled on the start cycle.
REQ-008 The block SHALL have ports x_addr (output, clog2(N_IN) bits) and x_ce (output, 1 bit): shared read port for input and weight memories.
REQ-009 The block SHALL have ports x_q (input, 12 bits, unsigned data) and w_q (input, 7 bits, signed weight); both are valid exactly 1 cycle after x_ce.
REQ-010 The block SHALL have ports mul_din0 (output, 12) and mul_din1 (output, 7) driving the shared combinational 12ns x 7s multiplier, and mul_dout (input, 19, signed) receiving its product.
REQ-011 The block SHALL have ports result (output, ACC_W, signed) and ovf (output, 1 bit): sticky saturation flag for the current run.

Function
REQ-012 The FSM SHALL have states IDLE, RUN, DRAIN and DONE.
REQ-013 In IDLE with ap_start=1, the FSM SHALL load acc<=bias, k<=0, clear ovf, and go to RUN; otherwise it stays in IDLE.
REQ-014 In RUN, the FSM SHALL assert x_ce=1 and x_addr=k and increment k; when k==N_IN-1 it goes to DRAIN.
REQ-015 A 1-cycle delayed copy of x_ce (rd_vld) SHALL qualify accumulation; while rd_vld=1, acc<=sat(acc + sext(mul_dout)).
REQ-016 mul_din0 SHALL equal x_q and mul_din1 SHALL equal w_q combinationally, with no register between memory data and multiplier.
REQ-017 DRAIN SHALL perform the final accumulate, then go to DONE.
REQ-018 In DONE, the FSM SHALL hold ap_done=1 and ap_ready=1 for exactly one cycle, then return to IDLE; ap_start is ignored in DONE.
REQ-019 Latency SHALL be: start accepted at cycle 0; addresses 0..N_IN-1 issued in cycles 1..N_IN; ap_done at cycle N_IN+2; the next start is accepted no earlier than cycle N_IN+3.
REQ-020 result SHALL update to the final acc on entry to DONE and hold until the next DONE; it is 0 after reset.
REQ-021 Saturation SHALL use an (ACC_W+1)-bit signed sum clamped to [-2^(ACC_W-1), 2^(ACC_W-1)-1]; any clamp sets ovf, which stays set until the next accepted start.
REQ-022 ap_idle SHALL be 1 only in IDLE; x_ce SHALL be 0 outside RUN.
REQ-023 mul_din0 and mul_din1 SHALL be driven to 0 when rd_vld=0, so there is no multiplier toggling when idle.

Reset
REQ-024 While ap_rst_n=0 at a clock edge, the block SHALL set state=IDLE, k=0, acc=0, rd_vld=0, result=0, ovf=0, ap_done=0, ap_ready=0, x_ce=0 and ap_idle=1.
REQ-025 Reset mid-run SHALL abandon the run with no ap_done pulse, and the block SHALL be startable on the first cycle after ap_rst_n returns to 1.

Structure
REQ-026 A shared package SHALL hold the state enum, DATA_W=12, WGT_W=7 and PROD_W=19.
REQ-027 The saturating adder SHALL be one sub-module, myproject_sat_add (ACC_W parameter), and the multiplier SHALL remain external.

Verification
REQ-028 Bench case: N_IN=4, x=[1,2,3,4], w=[1,1,1,1], bias=0 -> result=10, ovf=0, ap_done at cycle 6.
REQ-029 Bench case: N_IN=4, x=4095 x4, w=-64 x4, bias=0 -> result=-1048320, ovf=0.
REQ-030 Bench case: bias=8388000, x=4095, w=63 (ACC_W=24) -> result=8388607, ovf=1.
REQ-031 Bench case: bias=-8388608, x=1, w=-1 -> result=-8388608, ovf=1; the next run with w=0 clears ovf.
REQ-032 Bench case: ap_start held at 1 -> back-to-back runs, ap_done every N_IN+3 cycles, bias resampled each run.
REQ-033 Bench case: ap_rst_n=0 at cycle 3 of a run -> no ap_done, result=0, ap_idle=1; a restart then completes normally.

Source files
------------

// File: rtl/myproject_mac_seq_pkg.sv
// Shared types and widths for the sequential MAC: FSM states and the
// data/weight/product widths of the external 12u x 7s multiplier.
package myproject_mac_seq_pkg;

    localparam int DATA_W = 12;
    localparam int WGT_W  = 7;
    localparam int PROD_W = 19;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/myproject_mac_seq_sat_add.sv
// Saturating accumulate step: acc + sign-extended product, clamped to the
// signed ACC_W range, with a flag raised whenever the clamp engages.
module myproject_sat_add
    import myproject_mac_seq_pkg::*;
#(
    parameter int ACC_W = 24
) (
    input  logic signed [ACC_W-1:0]  a,
    input  logic signed [PROD_W-1:0] b,
    output logic signed [ACC_W-1:0]  sum,
    output logic                     clamp
);

    logic signed [ACC_W:0] wide;

    assign wide = $signed({a[ACC_W-1], a})
                + $signed({{(ACC_W+1-PROD_W){b[PROD_W-1]}}, b});

    // One guard bit suffices: a disagreeing top pair means the true sum left the range.
    always_comb begin
        sum   = wide[ACC_W-1:0];
        clamp = 1'b0;
        if (wide[ACC_W] != wide[ACC_W-1]) begin
            clamp = 1'b1;
            sum   = wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                : {1'b0, {(ACC_W-1){1'b1}}};
        end
    end

endmodule

// File: rtl/myproject_mac_seq.sv
// Sequential multiply-accumulate over N_IN memory words with HLS-style
// start/done handshake, shared external multiplier and saturating accumulator.
module myproject_mac_seq
    import myproject_mac_seq_pkg::*;
#(
    parameter int N_IN  = 16,
    parameter int ACC_W = 24
) (
    input  logic                       ap_clk,
    input  logic                       ap_rst_n,
    input  logic                       ap_start,
    output logic                       ap_done,
    output logic                       ap_idle,
    output logic                       ap_ready,
    input  logic signed [ACC_W-1:0]    bias,
    output logic [$clog2(N_IN)-1:0]    x_addr,
    output logic                       x_ce,
    input  logic [DATA_W-1:0]          x_q,
    input  logic signed [WGT_W-1:0]    w_q,
    output logic [DATA_W-1:0]          mul_din0,
    output logic signed [WGT_W-1:0]    mul_din1,
    input  logic signed [PROD_W-1:0]   mul_dout,
    output logic signed [ACC_W-1:0]    result,
    output logic                       ovf
);

    localparam int AW = $clog2(N_IN);
    localparam logic [AW-1:0] K_LAST = AW'(N_IN - 1);

    state_t                  state, state_n;
    logic [AW-1:0]           k;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_sum;
    logic                    acc_clamp;
    logic                    rd_vld;
    logic                    start_acc;

    myproject_sat_add #(.ACC_W(ACC_W)) u_sat_add (
        .a     (acc),
        .b     (mul_dout),
        .sum   (acc_sum),
        .clamp (acc_clamp)
    );

    // Memory data feeds the multiplier directly; gated so it stays quiet between reads.
    assign mul_din0 = rd_vld ? x_q : '0;
    assign mul_din1 = rd_vld ? w_q : '0;

    always_comb begin
        state_n   = state;
        start_acc = 1'b0;
        x_ce      = 1'b0;
        x_addr    = k;
        ap_idle   = 1'b0;
        ap_done   = 1'b0;
        ap_ready  = 1'b0;
        unique case (state)
            IDLE: begin
                ap_idle = 1'b1;
                if (ap_start) begin
                    start_acc = 1'b1;
                    state_n   = RUN;
                end
            end
            RUN: begin
                x_ce = 1'b1;
                if (k == K_LAST) state_n = DRAIN;
            end
            DRAIN: state_n = DONE;
            DONE: begin
                ap_done  = 1'b1;
                ap_ready = 1'b1;
                state_n  = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            state  <= IDLE;
            k      <= '0;
            acc    <= '0;
            rd_vld <= 1'b0;
            result <= '0;
            ovf    <= 1'b0;
        end else begin
            state  <= state_n;
            rd_vld <= x_ce;
            if (start_acc) begin
                acc <= bias;
                k   <= '0;
                ovf <= 1'b0;
            end else begin
                if (state == RUN) k <= k + AW'(1);
                if (rd_vld) begin
                    acc <= acc_sum;
                    if (acc_clamp) ovf <= 1'b1;
                end
            end
            // DRAIN always carries the last product, so its sum is the final value.
            if (state == DRAIN) result <= acc_sum;
        end
    end

endmodule

// File: tb/tb_myproject_mac_seq.sv
// Randomized scoreboard bench for myproject_mac_seq with a behavioural MAC model.
module tb_myproject_mac_seq;

    localparam int N_IN  = 4;
    localparam int ACC_W = 24;
    localparam int AW    = 2;

    logic                    ap_clk = 1'b0;
    logic                    ap_rst_n = 1'b0;
    logic                    ap_start = 1'b0;
    logic                    ap_done, ap_idle, ap_ready;
    logic signed [ACC_W-1:0] bias = '0;
    logic [AW-1:0]           x_addr;
    logic                    x_ce;
    logic [11:0]             x_q = '0;
    logic signed [6:0]       w_q = '0;
    logic [11:0]             mul_din0;
    logic signed [6:0]       mul_din1;
    logic signed [18:0]      mul_dout;
    logic signed [ACC_W-1:0] result;
    logic                    ovf;

    myproject_mac_seq #(.N_IN(N_IN), .ACC_W(ACC_W)) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start),
        .ap_done(ap_done), .ap_idle(ap_idle), .ap_ready(ap_ready),
        .bias(bias), .x_addr(x_addr), .x_ce(x_ce), .x_q(x_q), .w_q(w_q),
        .mul_din0(mul_din0), .mul_din1(mul_din1), .mul_dout(mul_dout),
        .result(result), .ovf(ovf)
    );

    always #5 ap_clk = ~ap_clk;

    int cyc = 0;
    always @(posedge ap_clk) cyc <= cyc + 1;

    // Memories with one-cycle read latency, plus the external multiplier.
    int x_mem [N_IN];
    int w_mem [N_IN];
    int nx [N_IN];
    int nw [N_IN];
    always @(posedge ap_clk) begin
        if (x_ce) begin
            x_q <= 12'(x_mem[x_addr]);
            w_q <= 7'(w_mem[x_addr]);
        end
    end
    assign mul_dout = $signed({1'b0, mul_din0}) * $signed(mul_din1);

    typedef struct {
        longint res;
        bit     ovf;
        int     done_cyc;
    } exp_t;
    exp_t sbq[$];
    exp_t mon_e;

    int n_chk = 0;
    int n_pass = 0;
    int last_issue = 0;
    int prev_issue = 0;

    task automatic check(input string name, input longint act, input longint req);
        n_chk++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    endtask

    function automatic exp_t model(input longint b);
        exp_t   e;
        longint a    = b;
        longint maxv = (longint'(1) << (ACC_W - 1)) - 1;
        longint minv = -(longint'(1) << (ACC_W - 1));
        e.ovf = 1'b0;
        for (int i = 0; i < N_IN; i++) begin
            a = a + longint'(x_mem[i]) * longint'(w_mem[i]);
            if (a > maxv) begin a = maxv; e.ovf = 1'b1; end
            if (a < minv) begin a = minv; e.ovf = 1'b1; end
        end
        e.res      = a;
        e.done_cyc = 0;
        return e;
    endfunction

    // Called at a negedge in the cycle where the DUT samples ap_start.
    task automatic issue(input longint b);
        exp_t e;
        for (int i = 0; i < N_IN; i++) begin
            x_mem[i] = nx[i];
            w_mem[i] = nw[i];
        end
        bias       = ACC_W'(b);
        ap_start   = 1'b1;
        e          = model(b);
        e.done_cyc = cyc + N_IN + 2;
        sbq.push_back(e);
        prev_issue = last_issue;
        last_issue = cyc;
    endtask

    task automatic wait_idle();
        int t = 0;
        @(negedge ap_clk);
        while (!ap_idle && t < 100) begin
            @(negedge ap_clk);
            t++;
        end
        if (!ap_idle) check("idle_timeout", 0, 1);
    endtask

    task automatic run(input longint b, input bit hold);
        wait_idle();
        issue(b);
        if (!hold) begin
            @(negedge ap_clk);
            ap_start = 1'b0;
        end
    endtask

    task automatic fill(input int xv, input int wv);
        for (int i = 0; i < N_IN; i++) begin
            nx[i] = xv;
            nw[i] = wv;
        end
    endtask

    task automatic fill_rand();
        for (int i = 0; i < N_IN; i++) begin
            nx[i] = int'($urandom_range(0, 4095));
            nw[i] = int'($urandom_range(0, 127)) - 64;
        end
    endtask

    function automatic longint rand_bias();
        return longint'($urandom_range(0, (1 << ACC_W) - 1)) - (longint'(1) << (ACC_W - 1));
    endfunction

    // Monitor: pops an expectation on each done pulse and watches idle quietness.
    always @(negedge ap_clk) begin
        if (ap_rst_n) begin
            if (ap_done) begin
                if (sbq.size() == 0) begin
                    check("spurious_done", 1, 0);
                end else begin
                    mon_e = sbq.pop_front();
                    check("result", longint'(result), mon_e.res);
                    check("ovf", longint'(ovf), longint'(mon_e.ovf));
                    check("done_cycle", cyc, mon_e.done_cyc);
                    check("ready_with_done", longint'(ap_ready), 1);
                end
            end else if (sbq.size() > 0 && cyc > sbq[0].done_cyc) begin
                check("done_timeout", cyc, sbq[0].done_cyc);
                void'(sbq.pop_front());
            end
            if (ap_idle) check("idle_quiet", longint'({x_ce, mul_din0, mul_din1}), 0);
        end
    end

    initial begin
        int t;
        // Reset state
        repeat (2) @(negedge ap_clk);
        check("rst_idle", longint'(ap_idle), 1);
        check("rst_done", longint'({ap_done, ap_ready}), 0);
        check("rst_result", longint'(result), 0);
        check("rst_ovf", longint'(ovf), 0);
        check("rst_xce", longint'(x_ce), 0);
        ap_rst_n = 1'b1;

        // Directed cases
        for (int i = 0; i < N_IN; i++) begin nx[i] = i + 1; nw[i] = 1; end
        run(0, 1'b0);
        fill(4095, -64);
        run(0, 1'b0);
        fill(4095, 63);
        run(8388000, 1'b0);
        fill(1, -1);
        run(-8388608, 1'b0);
        fill_rand();
        for (int i = 0; i < N_IN; i++) nw[i] = 0;
        run(0, 1'b0);

        // Back-to-back with ap_start held high
        fill_rand();
        run(rand_bias() >>> 4, 1'b1);
        for (int r = 0; r < 3; r++) begin
            fill_rand();
            run(rand_bias() >>> 4, (r != 2));
            check("b2b_spacing", last_issue - prev_issue, N_IN + 3);
        end

        // Randomized runs, including extreme biases that may saturate
        for (int r = 0; r < 10; r++) begin
            fill_rand();
            run((r % 3 == 0) ? rand_bias() : (rand_bias() >>> 6), 1'b0);
        end

        // Reset in the middle of a run
        wait_idle();
        fill_rand();
        issue(rand_bias());
        @(negedge ap_clk);
        ap_start = 1'b0;
        repeat (2) @(negedge ap_clk);
        ap_rst_n = 1'b0;
        sbq.delete();
        @(negedge ap_clk);
        check("midrst_result", longint'(result), 0);
        check("midrst_idle", longint'(ap_idle), 1);
        check("midrst_done", longint'(ap_done), 0);
        check("midrst_ovf", longint'(ovf), 0);
        ap_rst_n = 1'b1;
        fill_rand();
        issue(rand_bias() >>> 2);
        @(negedge ap_clk);
        check("restart_accepted", longint'(ap_idle), 0);
        ap_start = 1'b0;

        t = 0;
        while (sbq.size() > 0 && t < 50) begin
            @(negedge ap_clk);
            t++;
        end
        check("scoreboard_drained", sbq.size(), 0);
        repeat (2) @(negedge ap_clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
